// File: rtl/byte_stack_ctrl_if.sv
// ---------------------------------------------------------------------------
// byte_stack_ctrl_if
// Bus between the stack engine and the 8-bit byte memory.
//   cs   : chip select, low = selected
//   rw   : high = read, low = write
//   addr : memory address
//   din  : write data into the memory
//   dout : read data out of the memory
// master modport: the stack engine (drives cs/rw/addr/din, reads dout)
// slave  modport: the byte memory (reads cs/rw/addr/din, drives dout)
// ---------------------------------------------------------------------------
interface byte_stack_ctrl_if #(
    parameter int ADDRWIDTH = 3
);
    logic                 cs;
    logic                 rw;
    logic [ADDRWIDTH-1:0] addr;
    logic [7:0]           din;
    logic [7:0]           dout;

    modport master (
        output cs,
        output rw,
        output addr,
        output din,
        input  dout
    );

    modport slave (
        input  cs,
        input  rw,
        input  addr,
        input  din,
        output dout
    );
endinterface

// File: rtl/byte_stack_ctrl.sv
// ---------------------------------------------------------------------------
// byte_stack_ctrl
// Hardware stack engine in front of an 8-bit byte memory. Single-cycle
// push/pop requests become one-cycle memory write/read accesses; the engine
// keeps the stack count and reports full/empty plus sticky error flags.
// State updates on posedge clk; the memory acts on the following negedge.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   push       push request, decoded only while busy=0
//   pop        pop request, decoded only while busy=0 (push has priority)
//   push_data  byte to push
//   clr_err    clears overflow/underflow (a new error in the same cycle wins)
//   busy       high while a memory access is in flight
//   pop_data   last popped byte, held until the next pop
//   pop_valid  one-cycle pulse when pop_data updates
//   count      bytes currently on the stack (0..DEPTH)
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky, set by a push while full
//   underflow  sticky, set by a pop while empty
//   mem        memory bus (master side)
// ---------------------------------------------------------------------------
module byte_stack_ctrl #(
    parameter int ADDRWIDTH = 3,
    parameter int DEPTH     = 2**ADDRWIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [7:0]            push_data,
    input  logic                  clr_err,
    output logic                  busy,
    output logic [7:0]            pop_data,
    output logic                  pop_valid,
    output logic [ADDRWIDTH:0]    count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow,
    byte_stack_ctrl_if.master     mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t state;

    localparam logic [ADDRWIDTH:0] FULLCOUNT = (ADDRWIDTH+1)'(DEPTH);
    localparam logic [ADDRWIDTH:0] ONE       = (ADDRWIDTH+1)'(1);

    logic [ADDRWIDTH:0] count_dec;

    // Address of the top-of-stack byte for a pop.
    assign count_dec = count - ONE;

    // Flags are pure decodes of the registered count.
    assign full  = (count == FULLCOUNT);
    assign empty = (count == '0);

    // Main controller: a single registered FSM. Requests are only decoded in
    // IDLE, so anything arriving during WRITE/READ is simply dropped. The
    // memory bus is driven from registers so cs is low for exactly the one
    // WRITE or READ cycle, and addr/din keep their last values otherwise.
    // Error flags are cleared first so that a same-cycle error set overrides.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            count     <= '0;
            pop_valid <= 1'b0;
            pop_data  <= 8'h00;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            mem.cs    <= 1'b1;
            mem.rw    <= 1'b1;
            mem.addr  <= '0;
            mem.din   <= 8'h00;
        end else begin
            pop_valid <= 1'b0;
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            case (state)
                IDLE: begin
                    mem.cs <= 1'b1;
                    mem.rw <= 1'b1;
                    if (push) begin
                        if (full) begin
                            overflow <= 1'b1;
                        end else begin
                            mem.addr <= count[ADDRWIDTH-1:0];
                            mem.din  <= push_data;
                            mem.rw   <= 1'b0;
                            mem.cs   <= 1'b0;
                            state    <= WRITE;
                            busy     <= 1'b1;
                        end
                    end else if (pop) begin
                        if (empty) begin
                            underflow <= 1'b1;
                        end else begin
                            mem.addr <= count_dec[ADDRWIDTH-1:0];
                            mem.rw   <= 1'b1;
                            mem.cs   <= 1'b0;
                            state    <= READ;
                            busy     <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    count  <= count + ONE;
                    mem.cs <= 1'b1;
                    mem.rw <= 1'b1;
                    state  <= IDLE;
                    busy   <= 1'b0;
                end
                READ: begin
                    pop_data  <= mem.dout;
                    pop_valid <= 1'b1;
                    count     <= count_dec;
                    mem.cs    <= 1'b1;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    mem.cs <= 1'b1;
                    mem.rw <= 1'b1;
                    state  <= IDLE;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_byte_stack_ctrl
// Directed bench for byte_stack_ctrl with a negedge byte-memory model.
// ---------------------------------------------------------------------------
module tb_byte_stack_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] push_data;
    logic       clr_err;
    logic       busy;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       underflow;

    int nvec = 0;
    int nerr = 0;
    int cs_lows = 0;
    int pv_pulses = 0;

    byte_stack_ctrl_if #(.ADDRWIDTH(3)) memif ();

    byte_stack_ctrl #(.ADDRWIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .clr_err   (clr_err),
        .busy      (busy),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow),
        .mem       (memif.master)
    );

    // 100 MHz-style clock, period 10.
    always #5 clk = ~clk;

    // Byte memory model: acts on the negedge while selected.
    logic [7:0] tb_mem [0:7];
    logic [7:0] rd_q = 8'h00;
    always @(negedge clk) begin
        if (!memif.cs) begin
            if (!memif.rw) tb_mem[memif.addr] <= memif.din;
            else           rd_q <= tb_mem[memif.addr];
        end
    end
    assign memif.dout = rd_q;

    // Activity monitors sampled mid-cycle.
    always @(negedge clk) begin
        if (!memif.cs) cs_lows++;
        if (pop_valid) pv_pulses++;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [7:0] d);
        push = 1'b1; push_data = d;
        step();
        push = 1'b0;
        step();
    endtask

    task automatic do_pop();
        pop = 1'b1;
        step();
        pop = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = 8'h00; clr_err = 1'b0;
        step(); step();
        rst = 1'b0;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        nvec++; if (count !== 4'd0) begin nerr++; $display("[TB] FAIL reset_count got %0d exp 0", count); end
        nvec++; if (pop_valid !== 1'b0 || pop_data !== 8'h00) begin nerr++; $display("[TB] FAIL reset_pop got %b/%h exp 0/00", pop_valid, pop_data); end
        nvec++; if (overflow !== 1'b0 || underflow !== 1'b0) begin nerr++; $display("[TB] FAIL reset_err got %b%b exp 00", overflow, underflow); end
        nvec++; if (memif.cs !== 1'b1 || memif.rw !== 1'b1 || memif.addr !== 3'd0 || memif.din !== 8'h00) begin nerr++; $display("[TB] FAIL reset_bus got cs%b rw%b a%0d d%h exp cs1 rw1 a0 d00", memif.cs, memif.rw, memif.addr, memif.din); end
        nvec++; if (empty !== 1'b1 || full !== 1'b0) begin nerr++; $display("[TB] FAIL reset_flags got e%b f%b exp e1 f0", empty, full); end
    endtask

    task automatic test_push_single();
        push = 1'b1; push_data = 8'hA5;
        step();
        push = 1'b0;
        nvec++; if (memif.cs !== 1'b0 || memif.rw !== 1'b0 || memif.addr !== 3'd0 || memif.din !== 8'hA5) begin nerr++; $display("[TB] FAIL push_bus got cs%b rw%b a%0d d%h exp cs0 rw0 a0 dA5", memif.cs, memif.rw, memif.addr, memif.din); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("[TB] FAIL push_busy got %b exp 1", busy); end
        step();
        nvec++; if (busy !== 1'b0 || memif.cs !== 1'b1) begin nerr++; $display("[TB] FAIL push_done got busy%b cs%b exp busy0 cs1", busy, memif.cs); end
        nvec++; if (count !== 4'd1 || empty !== 1'b0) begin nerr++; $display("[TB] FAIL push_count got %0d e%b exp 1 e0", count, empty); end
        nvec++; if (tb_mem[0] !== 8'hA5) begin nerr++; $display("[TB] FAIL push_mem got %h exp A5", tb_mem[0]); end
        // Restore an empty stack for the next scenario.
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic test_lifo();
        logic [7:0] expv [3];
        expv[0] = 8'h33; expv[1] = 8'h22; expv[2] = 8'h11;
        do_push(8'h11); do_push(8'h22); do_push(8'h33);
        nvec++; if (count !== 4'd3) begin nerr++; $display("[TB] FAIL lifo_fill got %0d exp 3", count); end
        for (int i = 0; i < 3; i++) begin
            pop = 1'b1;
            step();
            pop = 1'b0;
            nvec++; if (pop_valid !== 1'b0 || memif.cs !== 1'b0 || memif.rw !== 1'b1 || memif.addr !== 3'(2 - i)) begin nerr++; $display("[TB] FAIL lifo_read%0d got pv%b cs%b rw%b a%0d exp pv0 cs0 rw1 a%0d", i, pop_valid, memif.cs, memif.rw, memif.addr, 2 - i); end
            step();
            nvec++; if (pop_valid !== 1'b1 || pop_data !== expv[i]) begin nerr++; $display("[TB] FAIL lifo_pop%0d got pv%b %h exp pv1 %h", i, pop_valid, pop_data, expv[i]); end
            step();
            nvec++; if (pop_valid !== 1'b0 || pop_data !== expv[i]) begin nerr++; $display("[TB] FAIL lifo_hold%0d got pv%b %h exp pv0 %h", i, pop_valid, pop_data, expv[i]); end
        end
        nvec++; if (count !== 4'd0 || empty !== 1'b1) begin nerr++; $display("[TB] FAIL lifo_end got %0d e%b exp 0 e1", count, empty); end
    endtask

    task automatic test_full_overflow();
        int snap;
        for (int i = 0; i < 8; i++) do_push(8'h40 + 8'(i));
        nvec++; if (full !== 1'b1 || count !== 4'd8) begin nerr++; $display("[TB] FAIL full_flag got f%b %0d exp f1 8", full, count); end
        snap = cs_lows;
        push = 1'b1; push_data = 8'hFF;
        step();
        push = 1'b0;
        nvec++; if (overflow !== 1'b1 || busy !== 1'b0) begin nerr++; $display("[TB] FAIL ovf_set got o%b busy%b exp o1 busy0", overflow, busy); end
        step();
        nvec++; if (cs_lows !== snap || count !== 4'd8) begin nerr++; $display("[TB] FAIL ovf_nocycle got cs_lows+%0d %0d exp +0 8", cs_lows - snap, count); end
        // Same-cycle clear and new overflow: the set must win.
        push = 1'b1; clr_err = 1'b1;
        step();
        push = 1'b0; clr_err = 1'b0;
        nvec++; if (overflow !== 1'b1) begin nerr++; $display("[TB] FAIL ovf_setwins got %b exp 1", overflow); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("[TB] FAIL ovf_clear got %b exp 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            do_pop();
            nvec++; if (pop_valid !== 1'b1 || pop_data !== 8'h47 - 8'(i)) begin nerr++; $display("[TB] FAIL drain%0d got pv%b %h exp pv1 %h", i, pop_valid, pop_data, 8'h47 - 8'(i)); end
        end
        nvec++; if (count !== 4'd0 || empty !== 1'b1) begin nerr++; $display("[TB] FAIL drain_end got %0d e%b exp 0 e1", count, empty); end
    endtask

    task automatic test_underflow();
        int snap;
        snap = cs_lows;
        pop = 1'b1;
        step();
        pop = 1'b0;
        nvec++; if (underflow !== 1'b1 || memif.cs !== 1'b1 || busy !== 1'b0) begin nerr++; $display("[TB] FAIL udf_set got u%b cs%b busy%b exp u1 cs1 busy0", underflow, memif.cs, busy); end
        step();
        nvec++; if (pop_valid !== 1'b0 || count !== 4'd0 || cs_lows !== snap) begin nerr++; $display("[TB] FAIL udf_quiet got pv%b %0d cs_lows+%0d exp pv0 0 +0", pop_valid, count, cs_lows - snap); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        nvec++; if (underflow !== 1'b0) begin nerr++; $display("[TB] FAIL udf_clear got %b exp 0", underflow); end
    endtask

    task automatic test_push_pop_same();
        int snap;
        do_push(8'hA1); do_push(8'hA2);
        snap = pv_pulses;
        push = 1'b1; pop = 1'b1; push_data = 8'hB3;
        step();
        push = 1'b0;
        nvec++; if (memif.cs !== 1'b0 || memif.rw !== 1'b0 || memif.addr !== 3'd2 || memif.din !== 8'hB3) begin nerr++; $display("[TB] FAIL pp_write got cs%b rw%b a%0d d%h exp cs0 rw0 a2 dB3", memif.cs, memif.rw, memif.addr, memif.din); end
        // pop still high here while busy=1: must be ignored.
        step();
        pop = 1'b0;
        nvec++; if (busy !== 1'b0 || memif.cs !== 1'b1 || count !== 4'd3) begin nerr++; $display("[TB] FAIL pp_done got busy%b cs%b %0d exp busy0 cs1 3", busy, memif.cs, count); end
        step();
        nvec++; if (pv_pulses !== snap || busy !== 1'b0 || count !== 4'd3) begin nerr++; $display("[TB] FAIL pp_nopop got pulses+%0d busy%b %0d exp +0 busy0 3", pv_pulses - snap, busy, count); end
        nvec++; if (tb_mem[2] !== 8'hB3) begin nerr++; $display("[TB] FAIL pp_mem got %h exp B3", tb_mem[2]); end
    endtask

    task automatic test_reset_mid_read();
        int snap;
        snap = pv_pulses;
        pop = 1'b1;
        step();
        pop = 1'b0;
        nvec++; if (busy !== 1'b1 || memif.cs !== 1'b0) begin nerr++; $display("[TB] FAIL rr_inread got busy%b cs%b exp busy1 cs0", busy, memif.cs); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        nvec++; if (busy !== 1'b0 || memif.cs !== 1'b1 || count !== 4'd0 || pop_valid !== 1'b0) begin nerr++; $display("[TB] FAIL rr_reset got busy%b cs%b %0d pv%b exp busy0 cs1 0 pv0", busy, memif.cs, count, pop_valid); end
        step();
        nvec++; if (pv_pulses !== snap || empty !== 1'b1) begin nerr++; $display("[TB] FAIL rr_nopulse got pulses+%0d e%b exp +0 e1", pv_pulses - snap, empty); end
    endtask

    initial begin
        test_reset();
        test_push_single();
        test_lifo();
        test_full_overflow();
        test_underflow();
        test_push_pop_same();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
